// File: rtl/key_serial_pkg.sv
// key_serial_pkg: shared types and constants for the key-window serial blocks
package key_serial_pkg;
  typedef enum logic {KS_HUNT, KS_LOCK} ks_state_t;
  localparam int KS_W = 8;
  localparam logic [7:0] KS_SYNC = 8'hA5;
  localparam logic KEY_BA13 = 1'b0;
  localparam logic KEY_BA12 = 1'b1;
endpackage

// File: rtl/key_serial_hold.sv
// key_serial_hold: single-entry holding register with valid/ack handshake and sticky overflow
module key_serial_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         ack,
  output logic [W-1:0] data,
  output logic         data_valid,
  output logic         overflow
);
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      data_valid <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      data_valid <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      if (!data_valid || ack) begin
        data <= word;
        data_valid <= 1'b1;
      end else overflow <= 1'b1;
    end else if (ack) data_valid <= 1'b0;
  end
endmodule

// File: rtl/key_serial_rx.sv
// key_serial_rx: samples SDRD on key-window reads, hunts for sync, then frames W-bit words
module key_serial_rx
  import key_serial_pkg::*;
#(
  parameter int W = KS_W,
  parameter logic [W-1:0] SYNC = W'(KS_SYNC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bus_sel,
  input  logic         sdrd_oe,
  input  logic         sdrd,
  input  logic         resync,
  output logic [W-1:0] data,
  output logic         data_valid,
  input  logic         data_ack,
  output logic         locked,
  output logic         overflow
);
  localparam int FW = $clog2(W + 1);
  localparam int CW = $clog2(W);
  ks_state_t state;
  logic [W-1:0] sh, nsh;
  logic [FW-1:0] fill;
  logic [CW-1:0] cnt;
  logic sample, complete;
  assign sample = bus_sel & sdrd_oe;
  assign nsh = {sh[W-2:0], sdrd};
  assign complete = sample & ~resync & (state == KS_LOCK) & (cnt == CW'(W - 1));
  always_ff @(posedge clk) begin
    if (rst || resync) begin
      state <= KS_HUNT;
      sh <= '0;
      fill <= '0;
      cnt <= '0;
      locked <= 1'b0;
    end else if (sample) begin
      sh <= nsh;
      if (state == KS_HUNT) begin
        fill <= (fill == FW'(W)) ? fill : fill + FW'(1);
        // fill counts bits before this one, so W-1 means this sample fills the window
        if (fill >= FW'(W - 1) && nsh == SYNC) begin
          state <= KS_LOCK;
          cnt <= '0;
          locked <= 1'b1;
        end
      end else cnt <= (cnt == CW'(W - 1)) ? '0 : cnt + CW'(1);
    end
  end
  key_serial_hold #(.W(W)) u_hold (
    .clk(clk),
    .rst(rst),
    .clr(resync),
    .load(complete),
    .word(nsh),
    .ack(data_ack),
    .data(data),
    .data_valid(data_valid),
    .overflow(overflow)
  );
endmodule

// File: tb/tb_key_serial_rx.sv
// tb_key_serial_rx: directed and random checks against a queue-based reference model
module tb_key_serial_rx;
  localparam int W = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clk = 1'b0, rst = 1'b1, bus_sel = 1'b0, sdrd_oe = 1'b0, sdrd = 1'b0;
  logic resync = 1'b0, data_ack = 1'b0;
  logic [W-1:0] data;
  logic data_valid, locked, overflow;
  int n_assert = 0, n_fail = 0;
  bit hunt_q[$];
  bit word_q[$];
  bit m_locked, m_valid, m_ovf;
  logic [7:0] m_data;

  key_serial_rx #(.W(W), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .sdrd_oe(sdrd_oe), .sdrd(sdrd),
    .resync(resync), .data(data), .data_valid(data_valid), .data_ack(data_ack),
    .locked(locked), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] q2v(input bit q[$]);
    logic [7:0] v = '0;
    foreach (q[i]) v = {v[6:0], q[i]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input bit full);
    hunt_q.delete();
    word_q.delete();
    m_locked = 0;
    m_valid = 0;
    m_ovf = 0;
    if (full) m_data = '0;
  endtask

  task automatic model(input bit bs, oe, b, rs, ack);
    bit comp = 0;
    logic [7:0] w = '0;
    if (rs) begin
      model_clear(0);
      return;
    end
    if (bs && oe) begin
      if (!m_locked) begin
        hunt_q.push_back(b);
        if (hunt_q.size() > W) void'(hunt_q.pop_front());
        if (hunt_q.size() == W && q2v(hunt_q) == SYNC) begin
          m_locked = 1;
          hunt_q.delete();
          word_q.delete();
        end
      end else begin
        word_q.push_back(b);
        if (word_q.size() == W) begin
          comp = 1;
          w = q2v(word_q);
          word_q.delete();
        end
      end
    end
    if (comp) begin
      if (!m_valid || ack) begin
        m_data = w;
        m_valid = 1;
      end else m_ovf = 1;
    end else if (ack) m_valid = 0;
  endtask

  task automatic check_all();
    chk("locked", 32'(locked), 32'(m_locked));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("data", 32'(data), 32'(m_data));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input bit bs, oe, b, rs, ack);
    bus_sel = bs; sdrd_oe = oe; sdrd = b; resync = rs; data_ack = ack;
    @(posedge clk);
    model(bs, oe, b, rs, ack);
    #1;
    bus_sel = 0; sdrd_oe = 0; resync = 0; data_ack = 0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_clear(1);
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] v, input bit ack_last);
    for (int i = 7; i >= 0; i--) cyc(1, 1, v[i], 0, ack_last && i == 0);
  endtask

  initial begin
    logic [7:0] v;
    model_clear(1);
    do_reset();
    chk("reset_locked", 32'(locked), 0);
    chk("reset_valid", 32'(data_valid), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_ovf", 32'(overflow), 0);
    // sync then data, with locked latency probe on the last sync bit
    v = SYNC;
    for (int i = 7; i >= 1; i--) cyc(1, 1, v[i], 0, 0);
    chk("lock_early", 32'(locked), 0);
    cyc(1, 1, v[0], 0, 0);
    chk("lock_after_sync", 32'(locked), 1);
    send_byte(8'h3C, 0);
    chk("word_3c", 32'(data), 32'h3C);
    chk("valid_3c", 32'(data_valid), 1);
    // no false lock
    do_reset();
    send_byte(8'h5A, 0);
    chk("nolock_5a", 32'(locked), 0);
    send_byte(8'h4B, 0);
    chk("nolock_4b", 32'(locked), 0);
    send_byte(8'hA5, 0);
    chk("lock_a5", 32'(locked), 1);
    // gaps inside a word
    do_reset();
    send_byte(SYNC, 0);
    v = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      cyc(1, 0, 1'($urandom), 0, 0);
      cyc(0, 1'($urandom), 1'($urandom), 0, 0);
      cyc(1, 1, v[i], 0, 0);
    end
    chk("gap_word", 32'(data), 32'hC3);
    // overflow
    do_reset();
    send_byte(SYNC, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("ovf_data", 32'(data), 32'h11);
    chk("ovf_set", 32'(overflow), 1);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_ack_valid", 32'(data_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    // same-cycle ack and completion
    do_reset();
    send_byte(SYNC, 0);
    send_byte(8'h55, 0);
    send_byte(8'h77, 1);
    chk("sameack_valid", 32'(data_valid), 1);
    chk("sameack_data", 32'(data), 32'h77);
    chk("sameack_ovf", 32'(overflow), 0);
    // resync, then reset, mid-word
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      send_byte(SYNC, 0);
      send_byte(8'h12, 0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 1'($urandom), 0, 0);
      if (pass == 0) cyc(1, 1, 1, 1, 0);
      else do_reset();
      chk("mid_locked", 32'(locked), 0);
      chk("mid_valid", 32'(data_valid), 0);
      send_byte(SYNC, 0);
      send_byte(8'h99, 0);
      chk("mid_data", 32'(data), 32'h99);
      chk("mid_valid2", 32'(data_valid), 1);
    end
    // random traffic, with occasional sync bytes to keep framing exercised
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) send_byte(SYNC, 0);
      for (int k = 0; k < 10; k++)
        cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), 1'($urandom),
            $urandom_range(0, 150) == 0, $urandom_range(0, 5) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
